// File: rtl/mult4x4_pkg.sv
// Shared constants and state type for the 4x4 shift-and-add multiplier.
package mult4x4_pkg;

  localparam int OPERAND_W = 4;
  localparam int PRODUCT_W = 8;
  localparam int COUNT_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult4x4_if.sv
// Operand/result bus between the multiplier and its user.
interface mult4x4_if;
  import mult4x4_pkg::*;

  logic                 start;
  logic [OPERAND_W-1:0] dataa;
  logic [OPERAND_W-1:0] datab;
  logic                 done_flag;
  logic [PRODUCT_W-1:0] product4x4_out;

  modport master (
    output start, dataa, datab,
    input  done_flag, product4x4_out
  );

  modport slave (
    input  start, dataa, datab,
    output done_flag, product4x4_out
  );

endinterface

// File: rtl/mult4x4_ctrl.sv
// Sequencer for the multiplier: IDLE -> CALC (four steps) -> DONE.
module mult4x4_ctrl
  import mult4x4_pkg::*;
(
  input  logic clk,
  input  logic reset_a,
  input  logic start,
  output logic load,
  output logic shift_en,
  output logic finish
);

  state_t               state;
  state_t               state_next;
  logic [COUNT_W-1:0]   count;

  always_ff @(posedge clk) begin
    if (reset_a) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Counter marks the step inside CALC; it wraps back to zero on the last step.
  always_ff @(posedge clk) begin
    if (reset_a) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (shift_en) begin
      count <= count + COUNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (&count) state_next = DONE;
      DONE:    if (start) state_next = CALC;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    shift_en = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: load = start;
      DONE: load = start;
      CALC: begin
        shift_en = 1'b1;
        finish   = &count;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult4x4.sv
// Sequential 4x4 unsigned shift-and-add multiplier with registered product and done flag.
module mult4x4
  import mult4x4_pkg::*;
(
  input  logic       clk,
  input  logic       reset_a,
  mult4x4_if.slave   bus
);

  logic                 load;
  logic                 shift_en;
  logic                 finish;
  logic [PRODUCT_W-1:0] multiplicand;
  logic [OPERAND_W-1:0] multiplier;
  logic [PRODUCT_W-1:0] accumulator;
  logic [PRODUCT_W-1:0] acc_next;
  logic [PRODUCT_W-1:0] product_reg;
  logic                 done_reg;

  mult4x4_ctrl u_ctrl (
    .clk      (clk),
    .reset_a  (reset_a),
    .start    (bus.start),
    .load     (load),
    .shift_en (shift_en),
    .finish   (finish)
  );

  assign acc_next = accumulator + (multiplier[0] ? multiplicand : '0);

  always_ff @(posedge clk) begin
    if (reset_a) begin
      multiplicand <= '0;
      multiplier   <= '0;
      accumulator  <= '0;
    end else if (load) begin
      multiplicand <= PRODUCT_W'(bus.dataa);
      multiplier   <= bus.datab;
      accumulator  <= '0;
    end else if (shift_en) begin
      accumulator  <= acc_next;
      multiplicand <= multiplicand << 1;
      multiplier   <= multiplier >> 1;
    end
  end

  // The product register only moves on the final step, so the partial sum never shows.
  always_ff @(posedge clk) begin
    if (reset_a) begin
      product_reg <= '0;
      done_reg    <= 1'b0;
    end else if (load) begin
      done_reg    <= 1'b0;
    end else if (finish) begin
      product_reg <= acc_next;
      done_reg    <= 1'b1;
    end
  end

  assign bus.product4x4_out = product_reg;
  assign bus.done_flag      = done_reg;

endmodule

// File: tb/tb_mult4x4.sv
// Self-checking bench for mult4x4: scenario tasks against an arithmetic reference (a*b after 4 cycles).
module tb_mult4x4;

  logic clk;
  logic reset_a;
  int   checks;
  int   failures;
  logic [7:0] last_product;

  mult4x4_if bus ();

  mult4x4 dut (
    .clk     (clk),
    .reset_a (reset_a),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_a   = 1'b1;
    bus.start = 1'b0;
    bus.dataa = 4'd0;
    bus.datab = 4'd0;
    tick();
    tick();
    checks++;
    if (bus.product4x4_out !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_product got=%h want=00", bus.product4x4_out);
    end
    checks++;
    if (bus.done_flag !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_done got=%b want=0", bus.done_flag);
    end
    reset_a = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (bus.done_flag !== 1'b0 || bus.product4x4_out !== 8'h00) begin
        failures++;
        $display("[TB] FAIL idle_stays got=%b/%h want=0/00", bus.done_flag, bus.product4x4_out);
      end
    end
    last_product = 8'h00;
  endtask

  task automatic test_basic();
    bus.dataa = 4'd3;
    bus.datab = 4'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (bus.done_flag !== 1'b0) begin
        failures++;
        $display("[TB] FAIL basic_early_done cycle=%0d got=%b want=0", c, bus.done_flag);
      end
    end
    tick();
    checks++;
    if (bus.done_flag !== 1'b1 || bus.product4x4_out !== 8'h0F) begin
      failures++;
      $display("[TB] FAIL basic_result got=%b/%h want=1/0f", bus.done_flag, bus.product4x4_out);
    end
    bus.dataa = 4'd9;
    bus.datab = 4'd9;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.done_flag !== 1'b1 || bus.product4x4_out !== 8'h0F) begin
        failures++;
        $display("[TB] FAIL basic_hold got=%b/%h want=1/0f", bus.done_flag, bus.product4x4_out);
      end
    end
    last_product = 8'h0F;
  endtask

  task automatic test_exhaustive();
    int order [256];
    int tmp;
    int j;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] want;
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    for (int k = 0; k < 256; k++) begin
      a = 4'(order[k] >> 4);
      b = 4'(order[k]);
      want = 8'(int'(a) * int'(b));
      bus.dataa = a;
      bus.datab = b;
      bus.start = 1'b1;
      tick();
      for (int c = 1; c <= 3; c++) begin
        bus.start = 1'($urandom_range(1, 0));
        bus.dataa = 4'($urandom);
        bus.datab = 4'($urandom);
        tick();
        checks++;
        if (bus.done_flag !== 1'b0) begin
          failures++;
          $display("[TB] FAIL exh_early_done %0d*%0d cycle=%0d got=%b want=0", a, b, c, bus.done_flag);
        end
        checks++;
        if (bus.product4x4_out !== last_product) begin
          failures++;
          $display("[TB] FAIL exh_hold_prev %0d*%0d got=%h want=%h", a, b, bus.product4x4_out, last_product);
        end
      end
      bus.start = 1'($urandom_range(1, 0));
      tick();
      checks++;
      if (bus.done_flag !== 1'b1) begin
        failures++;
        $display("[TB] FAIL exh_done %0d*%0d got=%b want=1", a, b, bus.done_flag);
      end
      checks++;
      if (bus.product4x4_out !== want) begin
        failures++;
        $display("[TB] FAIL exh_product %0d*%0d got=%h want=%h", a, b, bus.product4x4_out, want);
      end
      last_product = want;
    end
    bus.start = 1'b0;
    tick();
  endtask

  task automatic test_busy();
    bus.dataa = 4'd6;
    bus.datab = 4'd7;
    bus.start = 1'b1;
    tick();
    for (int c = 1; c <= 3; c++) begin
      bus.start = 1'b1;
      bus.dataa = 4'd15;
      bus.datab = 4'd15;
      tick();
    end
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.done_flag !== 1'b1 || bus.product4x4_out !== 8'h2A) begin
      failures++;
      $display("[TB] FAIL busy_result got=%b/%h want=1/2a", bus.done_flag, bus.product4x4_out);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (bus.done_flag !== 1'b1 || bus.product4x4_out !== 8'h2A) begin
        failures++;
        $display("[TB] FAIL busy_no_second got=%b/%h want=1/2a", bus.done_flag, bus.product4x4_out);
      end
    end
    last_product = 8'h2A;
  endtask

  task automatic test_back_to_back();
    bus.dataa = 4'd2;
    bus.datab = 4'd3;
    bus.start = 1'b1;
    tick();
    bus.dataa = 4'd4;
    bus.datab = 4'd4;
    for (int c = 0; c < 3; c++) tick();
    tick();
    checks++;
    if (bus.done_flag !== 1'b1 || bus.product4x4_out !== 8'h06) begin
      failures++;
      $display("[TB] FAIL b2b_first got=%b/%h want=1/06", bus.done_flag, bus.product4x4_out);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (bus.done_flag !== 1'b0 || bus.product4x4_out !== 8'h06) begin
        failures++;
        $display("[TB] FAIL b2b_second_calc cycle=%0d got=%b/%h want=0/06", c, bus.done_flag, bus.product4x4_out);
      end
    end
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.done_flag !== 1'b1 || bus.product4x4_out !== 8'h10) begin
      failures++;
      $display("[TB] FAIL b2b_second got=%b/%h want=1/10", bus.done_flag, bus.product4x4_out);
    end
    last_product = 8'h10;
  endtask

  task automatic test_reset_mid();
    bus.dataa = 4'd15;
    bus.datab = 4'd15;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    reset_a = 1'b1;
    tick();
    checks++;
    if (bus.done_flag !== 1'b0 || bus.product4x4_out !== 8'h00) begin
      failures++;
      $display("[TB] FAIL mid_reset got=%b/%h want=0/00", bus.done_flag, bus.product4x4_out);
    end
    reset_a = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (bus.done_flag !== 1'b0 || bus.product4x4_out !== 8'h00) begin
        failures++;
        $display("[TB] FAIL mid_no_completion got=%b/%h want=0/00", bus.done_flag, bus.product4x4_out);
      end
    end
    last_product = 8'h00;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    last_product = 8'h00;
    reset_a      = 1'b1;
    bus.start    = 1'b0;
    bus.dataa    = 4'd0;
    bus.datab    = 4'd0;
    test_reset();
    test_basic();
    test_exhaustive();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
